// File: rtl/ctrl_pipe.sv
// ctrl_pipe: DEPTH-cycle delay line for the start/valid/stop control triple, with protocol
// checking, frame occupancy (busy) and an output beat counter. Stall port via `CTRL_PIPE_STALL_EN.
module ctrl_pipe #(
  parameter int DEPTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 xrst,
`ifdef CTRL_PIPE_STALL_EN
  input  logic                 enable,
`endif
  input  logic                 in_start,
  input  logic                 in_valid,
  input  logic                 in_stop,
  input  logic                 err_clear,
  output logic                 out_start,
  output logic                 out_valid,
  output logic                 out_stop,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] beat_count,
  output logic                 err_protocol
);
  localparam int IW = $clog2(DEPTH + 2);
  localparam logic [IW-1:0]        INF_MAX  = {IW{1'b1}};
  localparam logic [CNT_WIDTH-1:0] BEAT_MAX = {CNT_WIDTH{1'b1}};

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  logic adv;
`ifdef CTRL_PIPE_STALL_EN
  assign adv = enable;
`else
  assign adv = 1'b1;
`endif

  logic [2:0]           stage_q [DEPTH];
  logic [2:0]           stage_d [DEPTH];
  state_t               state_q, state_d;
  logic                 err_q, err_d;
  logic [IW-1:0]        inflight_q, inflight_d;
  logic [CNT_WIDTH-1:0] beat_q, beat_d;
  logic                 new_err;
  logic                 inc, dec;

  assign out_start    = stage_q[DEPTH-1][2];
  assign out_valid    = stage_q[DEPTH-1][1];
  assign out_stop     = stage_q[DEPTH-1][0];
  assign busy         = (inflight_q != '0) || (state_q == ACTIVE);
  assign beat_count   = beat_q;
  assign err_protocol = err_q;

  always_comb begin
    stage_d = stage_q;
    if (adv) begin
      stage_d[0] = {in_start, in_valid, in_stop};
      for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
    end
  end

  // Illegal start/stop still travel down the pipe; only the frame state ignores them.
  always_comb begin
    new_err = 1'b0;
    state_d = state_q;
    if (adv) begin
      if (state_q == ACTIVE) begin
        new_err = in_start;
        if (in_stop) state_d = IDLE;
      end else begin
        new_err = (in_stop | in_valid) & ~in_start;
        if (in_start && !in_stop) state_d = ACTIVE;
      end
    end
`ifdef CTRL_PIPE_STALL_EN
    else begin
      new_err = in_start | in_valid | in_stop;
    end
`endif
    err_d = new_err | (err_q & ~err_clear);
  end

  always_comb begin
    inc        = adv & in_start;
    dec        = adv & out_stop;
    inflight_d = inflight_q;
    if (inc && !dec && inflight_q != INF_MAX)    inflight_d = inflight_q + IW'(1);
    else if (dec && !inc && inflight_q != '0)    inflight_d = inflight_q - IW'(1);
  end

  // Counter only moves on advancing cycles so a held output pulse is never counted twice.
  always_comb begin
    beat_d = beat_q;
    if (adv) begin
      if (out_start)                              beat_d = CNT_WIDTH'(out_valid);
      else if (out_valid && beat_q != BEAT_MAX)   beat_d = beat_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
      state_q    <= IDLE;
      err_q      <= 1'b0;
      inflight_q <= '0;
      beat_q     <= '0;
    end else begin
      stage_q    <= stage_d;
      state_q    <= state_d;
      err_q      <= err_d;
      inflight_q <= inflight_d;
      beat_q     <= beat_d;
    end
  end
endmodule
